uart_rx_byte: RTL and testbench

- UART byte receiver. Partner of uart_tx_byte; uses the same baud_set encoding.
- Frame format: 8N1, LSB first, idle-high line.
- Uses 16x oversampling with a 3-sample majority vote at mid-bit.
- Delivers one byte per frame with a 1-cycle done pulse, and flags framing errors.

---
 rtl/uart_rx_byte.sv | 172 +++++++++++++++++
 tb/tb_uart_rx_byte.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// Purpose : 8N1 UART byte receiver, 16x oversampled, 3-sample majority vote at mid-bit.
// Latency : rx_done about 9.5 bit periods plus synchronizer delay after the start edge.
// Backpr. : none; rx_done / frame_err are single-cycle pulses and data_byte holds the last good byte.
//
// Ports:
//   clk        system clock (CLK_FREQ Hz)
//   rst_n      asynchronous active-low reset
//   baud_set   0=2400 1=4800 2=9600 3=19200 4=38400 5=57600 6=115200 7=230400
//   uart_rx    serial line, idle high, asynchronous to clk
//   data_byte  last correctly received byte
//   rx_done    1-cycle pulse, data_byte valid in the same cycle
//   frame_err  1-cycle pulse when the stop bit is sampled low
module uart_rx_byte #(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] baud_set,
  input  logic       uart_rx,
  output logic [7:0] data_byte,
  output logic       rx_done,
  output logic       frame_err
);

  // The slowest baud rate has the largest divider; size the counter for it.
  localparam int DIV_W = $clog2(CLK_FREQ / (2400 * 16)) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Oversample divider terminal count (DIV-1) for a given baud select.
  function automatic logic [DIV_W-1:0] div_m1_of(input logic [2:0] sel);
    int unsigned baud;
    case (sel)
      3'd0:    baud = 2400;
      3'd1:    baud = 4800;
      3'd2:    baud = 9600;
      3'd3:    baud = 19200;
      3'd4:    baud = 38400;
      3'd5:    baud = 57600;
      3'd6:    baud = 115200;
      default: baud = 230400;
    endcase
    return DIV_W'(CLK_FREQ / (baud * 16) - 1);
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchronizer plus one delay flop for falling-edge detection.
  // All three reset to 1 so reset release never looks like a start edge.
  // ---------------------------------------------------------------------------
  logic rx_s1;
  logic rx_s2;
  logic rx_d;
  logic fall_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  assign fall_edge = rx_d & ~rx_s2;

  // ---------------------------------------------------------------------------
  // Receive FSM with oversample divider, tick counter and shift register.
  // ---------------------------------------------------------------------------
  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_m1_lat;
  logic [3:0]       tick_cnt;
  logic [2:0]       bit_idx;
  logic [1:0]       smp;
  logic [7:0]       shreg;
  logic             tick;
  logic             bit_maj;

  assign tick = (state != IDLE) && (div_cnt == div_m1_lat);

  // Majority of the samples taken at ticks 6 and 7 and the live sample at tick 8.
  assign bit_maj = (smp[0] & smp[1]) | (smp[0] & rx_s2) | (smp[1] & rx_s2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      div_cnt    <= '0;
      div_m1_lat <= '0;
      tick_cnt   <= 4'd0;
      bit_idx    <= 3'd0;
      smp        <= 2'b00;
      shreg      <= 8'h00;
      data_byte  <= 8'h00;
      rx_done    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;

      case (state)
        IDLE: begin
          if (fall_edge) begin
            state      <= START;
            div_cnt    <= '0;
            tick_cnt   <= 4'd0;
            bit_idx    <= 3'd0;
            // The frame runs entirely at the rate selected at its start edge.
            div_m1_lat <= div_m1_of(baud_set);
          end
        end

        default: begin
          if (!tick) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt  <= '0;
            tick_cnt <= tick_cnt + 4'd1;

            if (tick_cnt == 4'd6) smp[0] <= rx_s2;
            if (tick_cnt == 4'd7) smp[1] <= rx_s2;

            // Bit decision point.
            if (tick_cnt == 4'd8) begin
              case (state)
                START: begin
                  // A high majority means the edge was a glitch.
                  if (bit_maj) state <= IDLE;
                end
                DATA: begin
                  shreg[bit_idx] <= bit_maj;
                end
                STOP: begin
                  if (bit_maj) begin
                    data_byte <= shreg;
                    rx_done   <= 1'b1;
                  end else begin
                    frame_err <= 1'b1;
                  end
                  // Leave at mid stop bit so a closely following start edge
                  // is still seen.
                  state <= IDLE;
                end
                default: ;
              endcase
            end

            // End of bit period.
            if (tick_cnt == 4'd15) begin
              case (state)
                START: state <= DATA;
                DATA: begin
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) state <= STOP;
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
`timescale 1ns/1ps
module tb_uart_rx_byte;

  // A clock that divides every baud rate exactly keeps frame lengths short
  // while exercising the same divider logic as the 50 MHz build.
  localparam int unsigned CLK_FREQ = 7_372_800;
  localparam realtime     CLK_NS   = 1.0e9 / 7_372_800.0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] baud_set = 3'd6;
  logic       uart_rx = 1'b1;
  logic [7:0] data_byte;
  logic       rx_done;
  logic       frame_err;

  uart_rx_byte #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .baud_set  (baud_set),
    .uart_rx   (uart_rx),
    .data_byte (data_byte),
    .rx_done   (rx_done),
    .frame_err (frame_err)
  );

  always #(CLK_NS / 2.0) clk = ~clk;

  // ---------------------------------------------------------------------------
  // Model: every frame put on the line queues the one outcome it must produce.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit         err;
    logic [7:0] data;
    realtime    t0;
    bit         chk_lat;
    real        bit_ns;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       ev;
  logic [7:0] model_last = 8'h00;
  int         nchecks = 0;
  int         nerrors = 0;
  int         n_done = 0;
  int         n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nchecks++;
    if (act !== req) begin
      nerrors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Drive one 8N1 frame with the given bit time; stop_bit=0 forces a framing error.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input real bns,
                            input bit chk_lat);
    exp_t e;
    e.err     = !stop_bit;
    e.data    = d;
    e.t0      = $realtime;
    e.chk_lat = chk_lat;
    e.bit_ns  = bns;
    exp_q.push_back(e);
    uart_rx = 1'b0;
    #(bns);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      #(bns);
    end
    uart_rx = stop_bit;
    #(bns);
    uart_rx = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Compare process: every cycle out of reset.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_done && frame_err) begin
        nchecks++;
        nerrors++;
        $display("FAIL pulse_exclusive: rx_done=1 frame_err=1, required at most one high");
      end
      if (rx_done || frame_err) begin
        if (rx_done) n_done++;
        if (frame_err) n_err++;
        nchecks++;
        if (exp_q.size() == 0) begin
          nerrors++;
          $display("FAIL unexpected_pulse: rx_done=%b frame_err=%b, required no pulse",
                   rx_done, frame_err);
        end else begin
          ev = exp_q.pop_front();
          check("pulse_kind_frame_err", {31'd0, frame_err}, {31'd0, ev.err});
          if (!ev.err) model_last = ev.data;
          if (ev.chk_lat) begin
            // Decision lands near mid stop bit: 9.5 bits plus synchronizer,
            // within roughly one oversample tick.
            real lat, want, tol;
            lat  = $realtime - ev.t0;
            want = 9.5 * ev.bit_ns + 3.0 * CLK_NS;
            tol  = ev.bit_ns / 8.0 + 6.0 * CLK_NS;
            nchecks++;
            if (lat < want - tol || lat > want + tol) begin
              nerrors++;
              $display("FAIL latency: got %0.1f ns, required %0.1f +/- %0.1f ns", lat, want, tol);
            end
          end
        end
      end
      check("data_byte", {24'd0, data_byte}, {24'd0, model_last});
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus.
  // ---------------------------------------------------------------------------
  initial begin
    real b6;
    real b2;
    b6 = 1.0e9 / 115200.0;
    b2 = 1.0e9 / 9600.0;

    #(CLK_NS * 3.3);
    check("reset_data_byte", {24'd0, data_byte}, 32'h00);
    check("reset_rx_done",   {31'd0, rx_done},   32'h0);
    check("reset_frame_err", {31'd0, frame_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #(CLK_NS * 20);

    // Single frame at 115200.
    send_frame(8'hAA, 1'b1, b6, 1'b1);
    #(b6 * 2);
    check("aa_data", {24'd0, data_byte}, 32'hAA);

    // Back-to-back frames, no idle gap.
    send_frame(8'h55, 1'b1, b6, 1'b1);
    send_frame(8'h01, 1'b1, b6, 1'b1);
    #(b6 * 2);
    check("b2b_last_data", {24'd0, data_byte}, 32'h01);
    check("b2b_done_count", n_done, 3);

    // 100 ns low glitch on an idle line: no pulse, then a normal frame.
    @(negedge clk);
    #10;
    uart_rx = 1'b0;
    #100;
    uart_rx = 1'b1;
    #(b6);
    check("glitch_no_done", n_done, 3);
    check("glitch_no_err",  n_err,  0);
    send_frame(8'hC3, 1'b1, b6, 1'b1);
    #(b6 * 2);
    check("c3_data", {24'd0, data_byte}, 32'hC3);

    // Stop bit driven low: framing error, data_byte unchanged.
    send_frame(8'h3C, 1'b0, b6, 1'b0);
    #(b6 * 2);
    check("ferr_keeps_data", {24'd0, data_byte}, 32'hC3);
    check("ferr_count", n_err, 1);
    check("ferr_no_done", n_done, 4);
    send_frame(8'h3C, 1'b1, b6, 1'b1);
    #(b6 * 2);
    check("3c_data", {24'd0, data_byte}, 32'h3C);

    // 9600 frame with baud_set changed mid-frame: latched rate is used.
    baud_set = 3'd2;
    #(b6);
    fork
      send_frame(8'h7E, 1'b1, b2, 1'b1);
      begin
        #(b2 * 3.5);
        baud_set = 3'd6;
      end
    join
    #(b6 * 2);
    check("7e_data", {24'd0, data_byte}, 32'h7E);

    // Reset during data bit 4 of 8'hF0: aborted frame, no pulse.
    uart_rx = 1'b0;
    #(b6);
    for (int i = 0; i < 4; i++) begin
      uart_rx = 1'b0;
      #(b6);
    end
    uart_rx = 1'b1;
    #(b6 / 2.0);
    rst_n = 1'b0;
    model_last = 8'h00;
    #1;
    check("midrst_data_byte", {24'd0, data_byte}, 32'h00);
    check("midrst_rx_done",   {31'd0, rx_done},   32'h0);
    check("midrst_frame_err", {31'd0, frame_err}, 32'h0);
    #(CLK_NS * 10);
    @(negedge clk);
    rst_n = 1'b1;
    #(b6 * 2);
    check("midrst_no_pulse", n_done, 6);
    send_frame(8'h0F, 1'b1, b6, 1'b1);
    #(b6 * 2);
    check("0f_data", {24'd0, data_byte}, 32'h0F);

    // +/-2% baud error.
    send_frame(8'h96, 1'b1, b6 * 1.02, 1'b0);
    #(b6 * 2);
    check("slow2_data", {24'd0, data_byte}, 32'h96);
    send_frame(8'h69, 1'b1, b6 * 0.98, 1'b0);
    #(b6 * 3);
    check("fast2_data", {24'd0, data_byte}, 32'h69);

    check("all_frames_seen", exp_q.size(), 0);
    check("total_done", n_done, 9);
    check("total_err",  n_err,  1);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
